// File: rtl/palette_bank_lut.sv
// Multi-bank palette LUT: pixel index -> faded 8-bit RGB over a 2-stage pipeline.
// Bank switches and fade level steps land only on frame_tick so a frame never tears.
module palette_bank_lut #(
  parameter int IDX_W     = 4,
  parameter int BANKS     = 4,
  parameter int BANK_W    = 2,
  parameter int FADE_LOG2 = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic [BANK_W-1:0] bank_req,
  input  logic              idx_valid,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic              trans_en,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [23:0]       wr_rgb,
  input  logic              fade_out,
  input  logic              fade_in,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              out_valid,
  output logic              out_transparent,
  output logic [BANK_W-1:0] bank_active,
  output logic              fade_busy
);
  localparam int DEPTH = BANKS << IDX_W;
  localparam int LVL_W = FADE_LOG2 + 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(1 << FADE_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_BLACK, S_IN} fade_st_t;

  logic [DEPTH-1:0][23:0]    r_mem;
  logic [2:1]                r_vld_pipe;
  logic [23:0]               r_s1_rgb;
  logic                      r_s1_trans;
  logic [LVL_W-1:0]          r_level;
  fade_st_t                  r_state;
  logic [BANK_W+IDX_W-1:0]   w_waddr;
  logic [BANK_W+IDX_W-1:0]   w_raddr;
  logic [LVL_W-1:0]          w_gain;

  assign w_waddr   = {wr_bank, wr_idx};
  assign w_raddr   = {bank_active, idx_in};
  assign w_gain    = LVL_MAX - r_level;
  assign out_valid = r_vld_pipe[2];
  assign fade_busy = (r_state == S_OUT) || (r_state == S_IN);

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [LVL_W-1:0] g);
    logic [8+LVL_W-1:0] p;
    p = {{LVL_W{1'b0}}, c} * {8'd0, g};
    return p[FADE_LOG2 +: 8];
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_mem <= '0;
    else if (wr_en) r_mem[w_waddr] <= wr_rgb;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) bank_active <= '0;
    else if (frame_tick) bank_active <= bank_req;
  end

  // Stage 1 reads the pre-edge array, so a same-cycle write returns old data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vld_pipe <= '0;
      r_s1_rgb   <= '0;
      r_s1_trans <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], idx_valid};
      if (idx_valid) begin
        r_s1_rgb   <= r_mem[w_raddr];
        r_s1_trans <= trans_en && (idx_in == '0);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red             <= '0;
      Green           <= '0;
      Blue            <= '0;
      out_transparent <= 1'b0;
    end else if (r_vld_pipe[1]) begin
      Red             <= scale(r_s1_rgb[23:16], w_gain);
      Green           <= scale(r_s1_rgb[15:8],  w_gain);
      Blue            <= scale(r_s1_rgb[7:0],   w_gain);
      out_transparent <= r_s1_trans;
    end
  end

  // A direction change consumes the edge; the level only steps on later ticks.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_level <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (fade_out) r_state <= S_OUT;
        S_OUT: begin
          if (fade_in && !fade_out) r_state <= S_IN;
          else if (frame_tick) begin
            if (r_level >= LVL_MAX - LVL_W'(1)) begin
              r_level <= LVL_MAX;
              r_state <= S_BLACK;
            end else r_level <= r_level + LVL_W'(1);
          end
        end
        S_BLACK: if (fade_in) r_state <= S_IN;
        S_IN: begin
          if (fade_out && !fade_in) r_state <= S_OUT;
          else if (frame_tick) begin
            if (r_level <= LVL_W'(1)) begin
              r_level <= '0;
              r_state <= S_IDLE;
            end else r_level <= r_level - LVL_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_palette_bank_lut.sv
// Directed test-plan steps plus a random phase, each cycle compared against a
// behavioural model (array lookup, integer fade level/direction, plain arithmetic).
module tb_palette_bank_lut;
  localparam int IDX_W = 4, BANKS = 4, BANK_W = 2, FL = 3, LMAX = 1 << FL;

  logic Clk, Reset_n, frame_tick, idx_valid, trans_en, wr_en, fade_out, fade_in;
  logic [BANK_W-1:0] bank_req, wr_bank, bank_active;
  logic [IDX_W-1:0]  idx_in, wr_idx;
  logic [23:0]       wr_rgb;
  logic [7:0]        Red, Green, Blue;
  logic              out_valid, out_transparent, fade_busy;

  palette_bank_lut #(.IDX_W(IDX_W), .BANKS(BANKS), .BANK_W(BANK_W), .FADE_LOG2(FL)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .bank_req(bank_req),
    .idx_valid(idx_valid), .idx_in(idx_in), .trans_en(trans_en), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_rgb(wr_rgb), .fade_out(fade_out),
    .fade_in(fade_in), .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid),
    .out_transparent(out_transparent), .bank_active(bank_active), .fade_busy(fade_busy));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  // reference model state
  logic [23:0] m_mem [BANKS][1<<IDX_W];
  int          m_bank, m_lvl, m_dir;
  logic        m_s1v, m_s1t, m_ov, m_ot;
  logic [23:0] m_s1rgb;
  logic [7:0]  m_r, m_g, m_b;

  function automatic logic [7:0] fade(input logic [7:0] c, input int l);
    return 8'((int'(c) * (LMAX - l)) / LMAX);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < BANKS; b++)
      for (int i = 0; i < (1 << IDX_W); i++) m_mem[b][i] = '0;
    m_bank = 0; m_lvl = 0; m_dir = 0;
    m_s1v = 0; m_s1t = 0; m_s1rgb = '0;
    m_ov = 0; m_ot = 0; m_r = 0; m_g = 0; m_b = 0;
  endtask

  task automatic idle_inputs();
    frame_tick = 0; idx_valid = 0; idx_in = '0; trans_en = 0; wr_en = 0;
    wr_bank = '0; wr_idx = '0; wr_rgb = '0; fade_out = 0; fade_in = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, "_trans"}, 32'(out_transparent), 32'(m_ot));
    chk({tag, "_rgb"}, {8'd0, Red, Green, Blue}, {8'd0, m_r, m_g, m_b});
    chk({tag, "_bank"}, 32'(bank_active), 32'(m_bank));
    chk({tag, "_busy"}, 32'(fade_busy), 32'(m_dir != 0));
  endtask

  // One clock edge: advance the model from the pre-edge inputs, then compare.
  task automatic cyc();
    @(posedge Clk);
    if (m_s1v) begin
      m_r = fade(m_s1rgb[23:16], m_lvl);
      m_g = fade(m_s1rgb[15:8], m_lvl);
      m_b = fade(m_s1rgb[7:0], m_lvl);
      m_ot = m_s1t;
    end
    m_ov = m_s1v;
    m_s1v = idx_valid;
    if (idx_valid) begin
      m_s1rgb = m_mem[m_bank][idx_in];
      m_s1t = trans_en && (idx_in == 0);
    end
    if (wr_en) m_mem[wr_bank][wr_idx] = wr_rgb;
    if (frame_tick) m_bank = int'(bank_req);
    if (m_dir == 1 && fade_in && !fade_out) m_dir = -1;
    else if (m_dir == -1 && fade_out && !fade_in) m_dir = 1;
    else if (m_dir == 0 && m_lvl == 0 && fade_out) m_dir = 1;
    else if (m_dir == 0 && m_lvl == LMAX && fade_in) m_dir = -1;
    else if (frame_tick && m_dir != 0) begin
      m_lvl += m_dir;
      if (m_lvl >= LMAX) begin m_lvl = LMAX; m_dir = 0; end
      if (m_lvl <= 0) begin m_lvl = 0; m_dir = 0; end
    end
    #1;
    check_all("cyc");
  endtask

  task automatic wr(input int b, input int i, input logic [23:0] rgb);
    wr_en = 1; wr_bank = BANK_W'(b); wr_idx = IDX_W'(i); wr_rgb = rgb;
    cyc();
    wr_en = 0;
  endtask

  task automatic px(input int i, input logic te);
    idx_valid = 1; idx_in = IDX_W'(i); trans_en = te;
    cyc();
    idx_valid = 0; trans_en = 0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1; cyc(); frame_tick = 0; cyc();
    end
  endtask

  task automatic do_reset();
    #2;
    Reset_n = 0;
    idle_inputs();
    model_reset();
    #1;
    check_all("rst");
    @(posedge Clk);
    #2;
    Reset_n = 1;
  endtask

  initial begin
    Reset_n = 0;
    bank_req = '0;
    idle_inputs();
    model_reset();
    #12;
    check_all("por");
    Reset_n = 1;

    // basic lookup
    wr(0, 3, 24'h409858);
    px(3, 0);
    chk("tp1_rgb", {Red, Green, Blue}, 24'h409858);
    chk("tp1_valid", 32'(out_valid), 32'd1);
    chk("tp1_trans", 32'(out_transparent), 32'd0);

    // transparency
    wr(0, 0, 24'hFFFFFF);
    px(0, 1);
    chk("tp2_trans1", 32'(out_transparent), 32'd1);
    chk("tp2_rgb", {Red, Green, Blue}, 24'hFFFFFF);
    px(0, 0);
    chk("tp2_trans0", 32'(out_transparent), 32'd0);

    // bank switch only on frame_tick
    wr(2, 5, 24'hF8A0E0);
    bank_req = 2'd2;
    px(5, 0);
    chk("tp3_oldbank", {Red, Green, Blue}, 24'h000000);
    ticks(1);
    chk("tp3_bank", 32'(bank_active), 32'd2);
    px(5, 0);
    chk("tp3_newbank", {Red, Green, Blue}, 24'hF8A0E0);

    // read-before-write on the same entry
    wr(2, 1, 24'hAABBCC);
    wr_en = 1; wr_bank = 2'd2; wr_idx = 4'd1; wr_rgb = 24'h112233;
    idx_valid = 1; idx_in = 4'd1;
    cyc();
    wr_en = 0; idx_valid = 0;
    cyc();
    chk("tp4_old", {Red, Green, Blue}, 24'hAABBCC);
    px(1, 0);
    chk("tp4_new", {Red, Green, Blue}, 24'h112233);

    // fade out to half, to black, then back in
    wr(2, 7, 24'hF0A010);
    fade_out = 1; cyc(); fade_out = 0;
    ticks(4);
    px(7, 0);
    chk("tp5_half", {Red, Green, Blue}, 24'h785008);
    chk("tp5_busy", 32'(fade_busy), 32'd1);
    ticks(4);
    px(7, 0);
    chk("tp5_black", {Red, Green, Blue}, 24'h000000);
    chk("tp5_busy_blk", 32'(fade_busy), 32'd0);
    fade_in = 1; cyc(); fade_in = 0;
    ticks(8);
    px(7, 0);
    chk("tp5_full", {Red, Green, Blue}, 24'hF0A010);
    chk("tp5_idle", 32'(fade_busy), 32'd0);

    // random traffic, model compares every cycle
    for (int n = 0; n < 2000; n++) begin
      frame_tick = ($urandom_range(0, 7) == 0);
      bank_req   = BANK_W'($urandom_range(0, BANKS - 1));
      idx_valid  = ($urandom_range(0, 3) != 0);
      idx_in     = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
      trans_en   = $urandom_range(0, 1) == 1;
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_bank    = BANK_W'($urandom_range(0, BANKS - 1));
      wr_idx     = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
      wr_rgb     = 24'($urandom);
      fade_out   = ($urandom_range(0, 24) == 0);
      fade_in    = ($urandom_range(0, 24) == 0);
      cyc();
    end
    idle_inputs();
    bank_req = '0;

    // reset at fade level 5 with pixels in flight
    do_reset();
    wr(0, 2, 24'h808080);
    fade_out = 1; cyc(); fade_out = 0;
    ticks(5);
    idx_valid = 1; idx_in = 4'd2;
    cyc();
    do_reset();
    chk("tp6_valid", 32'(out_valid), 32'd0);
    chk("tp6_bank", 32'(bank_active), 32'd0);
    cyc();
    chk("tp6_valid2", 32'(out_valid), 32'd0);
    px(2, 0);
    chk("tp6_cleared", {Red, Green, Blue}, 24'h000000);
    wr(0, 2, 24'hC0C0C0);
    px(2, 0);
    chk("tp6_lvl0", {Red, Green, Blue}, 24'hC0C0C0);
    chk("tp6_busy", 32'(fade_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/palette_bank_lut.md
Name: palette_bank_lut

Overview:
Parametrised successor to the fixed per-scene palette decoders. It holds several writable palette banks in a flop array and converts a sprite/background pixel index to registered 8-bit RGB through a 2-stage pipeline. It adds tear-free bank switching on frame boundaries, a transparency flag, and a frame-stepped fade-to-black/fade-in engine. It sits between the frame/sprite pixel fetch and the VGA colour outputs.

Parameters:
IDX_W, 4, pixel index width; entries per bank = 2^IDX_W
BANKS, 4, number of palette banks (power of two, >=2)
BANK_W, 2, log2(BANKS)
FADE_LOG2, 3, fade resolution; fade level range 0..2^FADE_LOG2

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
bank_req  in  BANK_W  requested bank; applied at next frame_tick
idx_valid  in  1  pixel index valid this cycle
idx_in  in  IDX_W  pixel index
trans_en  in  1  treat index 0 as transparent
wr_en  in  1  palette write strobe
wr_bank  in  BANK_W  write bank
wr_idx  in  IDX_W  write entry
wr_rgb  in  24  {R,G,B} write data
fade_out  in  1  pulse: start fade to black
fade_in  in  1  pulse: start fade from black
Red, Green, Blue  out  8 each  pixel colour
out_valid  out  1  colour valid
out_transparent  out  1  pixel is transparent
bank_active  out  BANK_W  bank currently in use
fade_busy  out  1  fade in progress

Behaviour:
- Reset (async, Reset_n low): all palette entries = 24'h000000; Red/Green/Blue = 0; out_valid = 0; out_transparent = 0; bank_active = 0; fade level = 0; FSM = IDLE; fade_busy = 0. Reset mid-fade or mid-pipeline discards everything.
- Bank switch: bank_req sampled only on frame_tick; bank_active updates on that edge. Never changes mid-frame.
- Stage 1 (edge after idx_valid): read entry[bank_active][idx_in] into RGB register; register valid, transparency = trans_en && idx_in == 0.
- Stage 2: each channel c -> (c * (2^FADE_LOG2 - level)) >> FADE_LOG2, full-width product, truncate; drive outputs. Total latency 2 cycles, fully pipelined, one pixel/cycle, no stalls.
- out_valid low -> Red/Green/Blue/out_transparent hold last values.
- Write: entry updated on edge where wr_en = 1. Read and write to same entry in same cycle returns OLD data (read-before-write); new data visible from next cycle.
- Fade FSM (level changes only on frame_tick):
  IDLE (level 0): fade_out -> FADE_OUT; fade_in ignored.
  FADE_OUT: level +1 per frame_tick; at 2^FADE_LOG2 -> BLACK.
  BLACK (level max, outputs 0): fade_in -> FADE_IN; fade_out ignored.
  FADE_IN: level -1 per frame_tick; at 0 -> IDLE.
  Opposite pulse during FADE_OUT/FADE_IN reverses direction from current level (no jump). Same-direction pulse ignored. fade_out and fade_in together: fade_in ignored in IDLE, fade_out ignored in BLACK, both ignored while fading.
  fade_busy = 1 in FADE_OUT and FADE_IN.
- A fade pulse coincident with frame_tick changes state that edge; first level step occurs on the next frame_tick.
- Level change takes effect for pixels entering stage 2 after the edge.

Test Plan:
- Reset, write bank0 idx3 = 24'h409858, idx_valid idx 3 -> two cycles later RGB = 40/98/58, out_valid = 1, out_transparent = 0.
- trans_en = 1, idx 0 (entry 24'hFFFFFF) -> out_transparent = 1, RGB = FF/FF/FF; trans_en = 0 -> out_transparent = 0.
- Write bank2 idx5 = 24'hF8A0E0, bank_req = 2 with no frame_tick -> still bank 0 data; after frame_tick, idx 5 -> F8/A0/E0, bank_active = 2.
- Same-cycle write idx1 = 24'h112233 over old 24'hAABBCC with read idx1 -> AA/BB/CC; next read -> 11/22/33.
- Entry 24'hF0A010, fade_out, 4 frame_ticks -> R = 78, G = 50, B = 08, fade_busy = 1; 4 more -> 00/00/00, BLACK, fade_busy = 0; fade_in + 8 ticks -> F0/A0/10, IDLE.
- Reset_n low for 1 cycle at fade level 5 with pixels in flight -> out_valid = 0, level = 0, bank_active = 0, entries = 0.
